// File: rtl/mux_8to1_pkg.sv
// Shared types for the 8-channel round-robin merger.
// Optional packet locking is enabled by defining MUX_PKT_LOCK_EN.
package mux_8to1_pkg;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    ARB,
    LOCK
  } state_t;
endpackage

// File: rtl/mux_8to1_rr_arb8.sv
// Combinational 8-way round-robin arbiter: rotate the request vector so ptr
// sits at bit 0, take the lowest set bit, then rotate the index back.
module rr_arb8
  import mux_8to1_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  sel_t              ptr,
  output logic              gnt_vld,
  output sel_t              gnt_idx
);

  logic [NUM_CH-1:0] rot;
  sel_t              off;

  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rot[i] = req[sel_t'(i) + ptr];
    end
  end

  // Highest index first so the lowest set bit wins.
  always_comb begin
    off = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) off = sel_t'(i);
    end
  end

  assign gnt_vld = |req;
  assign gnt_idx = off + ptr;

endmodule

// File: rtl/mux_8to1_rr.sv
// Eight-channel round-robin merger onto one registered valid/ready stream.
// Define MUX_PKT_LOCK_EN to add in_last/out_last and hold the grant for whole packets.
module mux_8to1_rr
  import mux_8to1_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
`ifdef MUX_PKT_LOCK_EN
  input  logic [NUM_CH-1:0]        in_last,
  output logic                     out_last,
`endif
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output sel_t                     out_sel,
  input  logic                     out_ready
);

  state_t            state, state_nxt;
  sel_t              ptr;
  sel_t              lock_ch;
  logic              load;
  logic              accept;
  logic              gnt_vld;
  sel_t              gnt_idx;
  logic              last_g;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] last_bits;

`ifdef MUX_PKT_LOCK_EN
  assign last_bits = in_last;
`else
  // Every beat is its own packet, so the FSM never leaves ARB.
  assign last_bits = '1;
`endif

  assign load   = ~out_valid | out_ready;
  assign accept = load & gnt_vld;
  assign last_g = last_bits[gnt_idx];

  always_comb begin
    req = in_valid;
    if (state == LOCK) req = in_valid & (NUM_CH'(1) << lock_ch);
  end

  rr_arb8 u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    in_ready = '0;
    if (rst_n && accept) in_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (accept && !last_g) state_nxt = LOCK;
      LOCK:    if (accept && last_g)  state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB;
      lock_ch <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB && accept) lock_ch <= gnt_idx;
    end
  end

  // ptr only moves on ARB grants and on the closing beat of a locked packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= gnt_vld;
      if (gnt_vld) begin
        out_data <= in_data[gnt_idx*DATA_W +: DATA_W];
        out_sel  <= gnt_idx;
        if (state == ARB || last_g) ptr <= gnt_idx + sel_t'(1);
      end
    end
  end

`ifdef MUX_PKT_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      out_last <= 1'b0;
    else if (accept) out_last <= last_g;
  end
`endif

endmodule

// File: tb/tb_mux_8to1_rr.sv
// Scoreboard bench for mux_8to1_rr; packet-lock scenario runs only when
// MUX_PKT_LOCK_EN is defined.
module tb_mux_8to1_rr;
  import mux_8to1_pkg::*;

  localparam int DATA_W = 8;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  sel_t                     out_sel;
  logic                     out_ready;
`ifdef MUX_PKT_LOCK_EN
  logic [NUM_CH-1:0]        in_last;
  logic                     out_last;
`endif

  mux_8to1_rr #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
`ifdef MUX_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t      sb[$];
  beat_t      mon_e;
  int         checks   = 0;
  int         failures = 0;
  int         m_ptr    = 0;
  logic       m_valid  = 1'b0;
  logic       m_valid_nxt = 1'b0;
  logic       m_lock   = 1'b0;
  int         m_ch     = 0;
  logic [7:0] exp_ready;

  function automatic logic [7:0] data_of(input int ch, input logic [7:0] tag);
    return 8'(ch * 17) ^ tag;
  endfunction

  // Drives one cycle of inputs and advances the reference model.
  task automatic drive(input logic [7:0] v, input logic ordy,
                       input logic [7:0] last, input logic [7:0] tag);
    logic [7:0] req;
    int         g;
    logic       found;
    in_valid  = v;
    out_ready = ordy;
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = data_of(i, tag);
`ifdef MUX_PKT_LOCK_EN
    in_last = last;
`endif
    req   = m_lock ? (v & (8'b1 << m_ch)) : v;
    found = 1'b0;
    g     = 0;
    for (int k = 0; k < 8; k++) begin
      if (!found && req[(m_ptr + k) % 8]) begin
        found = 1'b1;
        g     = (m_ptr + k) % 8;
      end
    end
    exp_ready   = '0;
    m_valid_nxt = m_valid;
    if (!m_valid || ordy) begin
      m_valid_nxt = found;
      if (found) begin
        exp_ready[g] = 1'b1;
        sb.push_back('{3'(g), data_of(g, tag), last[g]});
        if (!m_lock) begin
          m_ptr = (g + 1) % 8;
          if (!last[g]) begin
            m_lock = 1'b1;
            m_ch   = g;
          end
        end else if (last[g]) begin
          m_lock = 1'b0;
          m_ptr  = (g + 1) % 8;
        end
      end
    end
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    m_valid = m_valid_nxt;
  endtask

  // Scoreboard: a beat leaves the DUT when out_valid & out_ready at the edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL sb_pop: got beat sel=%0d data=%h, expected no beat", out_sel, out_data);
      end else begin
        mon_e = sb.pop_front();
        if (out_sel !== mon_e.sel || out_data !== mon_e.data) begin
          failures++;
          $display("[TB] FAIL sb_beat: got sel=%0d data=%h, expected sel=%0d data=%h",
                   out_sel, out_data, mon_e.sel, mon_e.data);
        end
`ifdef MUX_PKT_LOCK_EN
        checks++;
        if (out_last !== mon_e.last) begin
          failures++;
          $display("[TB] FAIL sb_last: got %b, expected %b", out_last, mon_e.last);
        end
`endif
      end
    end
  end

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 8'hFF;
    out_ready = 1'b0;
    in_data   = '0;
`ifdef MUX_PKT_LOCK_EN
    in_last   = '1;
`endif
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_sel !== 3'd0 || out_data !== 8'h00 || in_ready !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_values: got valid=%b sel=%0d data=%h ready=%h, expected 0/0/00/00",
               out_valid, out_sel, out_data, in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(8'h02, 1'b0, 8'hFF, 8'h30);
    checks++;
    if (in_ready !== 8'h02) begin
      failures++;
      $display("[TB] FAIL reset_pre_grant: got %h, expected 02", in_ready);
    end
    tick();
    drive(8'h02, 1'b0, 8'hFF, 8'h31);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_stall: got valid=%b ready=%h, expected 1/00", out_valid, in_ready);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_async: got valid=%b ready=%h, expected 0/00", out_valid, in_ready);
    end
    sb.delete();
    m_valid     = 1'b0;
    m_valid_nxt = 1'b0;
    m_ptr       = 0;
    m_lock      = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_all_valid;
    for (int i = 0; i < 10; i++) begin
      drive(8'hFF, 1'b1, 8'hFF, 8'h00);
      checks++;
      if (in_ready !== (8'b1 << (i % 8))) begin
        failures++;
        $display("[TB] FAIL all_valid_grant%0d: got %h, expected %h", i, in_ready, 8'b1 << (i % 8));
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 3'(i % 8)) begin
        failures++;
        $display("[TB] FAIL all_valid_out%0d: got valid=%b sel=%0d, expected 1/%0d",
                 i, out_valid, out_sel, i % 8);
      end
    end
    drive(8'h00, 1'b1, 8'hFF, 8'h00);
    tick();
  endtask

  task automatic test_skip;
    drive(8'h04, 1'b1, 8'hFF, 8'h10);
    tick();
    drive(8'h84, 1'b1, 8'hFF, 8'h11);
    checks++;
    if (in_ready !== 8'h80) begin
      failures++;
      $display("[TB] FAIL skip_first: got %h, expected 80", in_ready);
    end
    tick();
    drive(8'h84, 1'b1, 8'hFF, 8'h12);
    checks++;
    if (in_ready !== 8'h04) begin
      failures++;
      $display("[TB] FAIL skip_second: got %h, expected 04", in_ready);
    end
    tick();
    drive(8'hFF, 1'b1, 8'hFF, 8'h13);
    checks++;
    if (in_ready !== 8'h08) begin
      failures++;
      $display("[TB] FAIL skip_ptr: got %h, expected 08", in_ready);
    end
    tick();
    drive(8'h00, 1'b1, 8'hFF, 8'h00);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL skip_idle: got valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_stall;
    drive(8'h02, 1'b1, 8'hFF, 8'h40);
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(8'h02, 1'b0, 8'hFF, 8'(8'h41 + c));
      checks++;
      if (in_ready !== 8'h00 || out_valid !== 1'b1 || out_sel !== 3'd1 || out_data !== data_of(1, 8'h40)) begin
        failures++;
        $display("[TB] FAIL stall_hold%0d: got ready=%h valid=%b sel=%0d data=%h, expected 00/1/1/%h",
                 c, in_ready, out_valid, out_sel, out_data, data_of(1, 8'h40));
      end
      tick();
    end
    drive(8'h02, 1'b1, 8'hFF, 8'h50);
    checks++;
    if (in_ready !== 8'h02) begin
      failures++;
      $display("[TB] FAIL stall_release: got %h, expected 02", in_ready);
    end
    tick();
    drive(8'h00, 1'b1, 8'hFF, 8'h00);
    tick();
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL stall_drain: got valid=%b pending=%0d, expected 0/0", out_valid, sb.size());
    end
  endtask

  task automatic test_wrap;
    drive(8'h40, 1'b1, 8'hFF, 8'h60);
    tick();
    drive(8'h80, 1'b1, 8'hFF, 8'h61);
    checks++;
    if (in_ready !== 8'h80) begin
      failures++;
      $display("[TB] FAIL wrap_grant7: got %h, expected 80", in_ready);
    end
    tick();
    drive(8'h00, 1'b1, 8'hFF, 8'h62);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wrap_idle: got valid=%b, expected 0", out_valid);
    end
    drive(8'h81, 1'b1, 8'hFF, 8'h63);
    checks++;
    if (in_ready !== 8'h01) begin
      failures++;
      $display("[TB] FAIL wrap_ptr0: got %h, expected 01", in_ready);
    end
    tick();
    drive(8'h00, 1'b1, 8'hFF, 8'h00);
    tick();
  endtask

`ifdef MUX_PKT_LOCK_EN
  task automatic test_pkt_lock;
    logic [7:0] rdy_exp [5];
    logic [7:0] vld_seq [5];
    logic [7:0] lst_seq [5];
    vld_seq = '{8'h24, 8'h20, 8'h24, 8'h24, 8'h20};
    lst_seq = '{8'hFB, 8'hFB, 8'hFB, 8'hFF, 8'hFF};
    rdy_exp = '{8'h04, 8'h00, 8'h04, 8'h04, 8'h20};
    for (int i = 0; i < 5; i++) begin
      drive(vld_seq[i], 1'b1, lst_seq[i], 8'(8'h70 + i));
      checks++;
      if (in_ready !== rdy_exp[i]) begin
        failures++;
        $display("[TB] FAIL pkt_lock%0d: got %h, expected %h", i, in_ready, rdy_exp[i]);
      end
      tick();
    end
    drive(8'h00, 1'b1, 8'hFF, 8'h00);
    tick();
  endtask
`endif

  task automatic test_final;
    drive(8'h00, 1'b1, 8'hFF, 8'h00);
    tick();
    tick();
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL final_drain: got pending=%0d valid=%b, expected 0/0", sb.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_all_valid();
    test_skip();
    test_stall();
    test_wrap();
`ifdef MUX_PKT_LOCK_EN
    test_pkt_lock();
`endif
    test_final();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
